// File: rtl/hack_mem_bus_ctrl.sv
// Hack CPU data-memory bus sequencer: latch request, decode, drive RAM or I/O, ack.
// Ack arrives 3 cycles after request for RAM/I/O (plus RAM waits), 2 for unmapped; CPU stalls until then.
module hack_mem_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_ack,
  output logic        bus_err,
  output logic [15:0] dec_addr,
  input  logic [2:0]  slave_sel,
  output logic [13:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_re,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  input  logic        ram_ready,
  output logic        io_re,
  output logic        io_we,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    state;
  logic [15:0]   addr_q;
  logic [15:0]   wdata_q;
  logic          we_q;
  logic [2:0]    sel_q;
  logic [CW-1:0] cnt;
  logic          err_q;
  logic [15:0]   rdata_q;

  logic ram_sel;
  logic io_sel;
  logic dec_ok;

  assign ram_sel = (sel_q == 3'b001);
  assign io_sel  = (sel_q == 3'b010);
  assign dec_ok  = (slave_sel == 3'b001) || (slave_sel == 3'b010);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            we_q    <= cpu_we;
            state   <= DECODE;
          end
        end
        DECODE: begin
          sel_q <= slave_sel;
          if (dec_ok) begin
            state <= ACCESS;
          end else begin
            err_q <= 1'b1;
            if (!we_q) rdata_q <= '0;
            state <= DONE;
          end
        end
        ACCESS: begin
          if (ram_sel) begin
            cnt <= cnt + 1'b1;
            if (ram_ready) begin
              if (!we_q) rdata_q <= ram_rdata;
              state <= DONE;
            end else if (cnt == LAST_WAIT) begin
              err_q <= 1'b1;
              if (!we_q) rdata_q <= '0;
              state <= DONE;
            end
          end else if (io_sel) begin
            if (!we_q) rdata_q <= io_rdata;
            state <= DONE;
          end else begin
            // Unreachable: DECODE only enters ACCESS with a valid select.
            err_q <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          cnt   <= '0;
          err_q <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded from state so they drop on the same edge that leaves ACCESS.
  assign ram_re    = (state == ACCESS) && ram_sel && !we_q;
  assign ram_we    = (state == ACCESS) && ram_sel &&  we_q;
  assign io_re     = (state == ACCESS) && io_sel  && !we_q;
  assign io_we     = (state == ACCESS) && io_sel  &&  we_q;

  assign dec_addr  = addr_q;
  assign ram_addr  = addr_q[13:0];
  assign ram_wdata = wdata_q;
  assign io_wdata  = wdata_q;

  assign cpu_rdata = rdata_q;
  assign cpu_ack   = (state == DONE);
  assign bus_err   = (state == DONE) && err_q;
  assign cpu_stall = ((state == IDLE) && cpu_req) || (state == DECODE) || (state == ACCESS);

endmodule
